// File: rtl/rr_grant_sched.sv
// Registered round-robin arbiter for three requesters with a hold-time limit.
// Optional illegal-state recovery is enabled by defining RR_GRANT_SCHED_STATE_RECOVERY_EN.
module rr_grant_sched #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic r1,
   input  logic r2,
   input  logic r3,
   output logic g1,
   output logic g2,
   output logic g3,
   output logic busy,
   output logic err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT1 = 2'd1,
      GNT2 = 2'd2,
      GNT3 = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_r;
   state_t           state_nx_s;
   logic [1:0]       last_r;
   logic [1:0]       last_nx_s;
   logic [CNT_W-1:0] hold_cnt_r;
   logic [CNT_W-1:0] hold_nx_s;
   logic [3:0]       req_s;
   logic [1:0]       cur_s;
   logic [1:0]       win_s;
   logic             grant_en_s;
   logic [2:0]       grant_nx_s;

   // Rotation search: first active request after 'last', wrapping 3 -> 1; 0 means none.
   function automatic logic [1:0] pick(input logic [1:0] last, input logic [3:0] req);
      logic [1:0] n;
      logic [1:0] found;
      found = 2'd0;
      n     = last;
      for (int i = 0; i < 3; i++) begin
         n = (n == 2'd3) ? 2'd1 : n + 2'd1;
         if ((found == 2'd0) && req[n]) begin
            found = n;
         end else begin
            found = found;
         end
      end
      return found;
   endfunction

   function automatic logic [2:0] decode(input logic [1:0] st);
      logic [2:0] g;
      case (st)
         2'd1:    g = 3'b001;
         2'd2:    g = 3'b010;
         2'd3:    g = 3'b100;
         default: g = 3'b000;
      endcase
      return g;
   endfunction

   function automatic logic onehot0(input logic [2:0] v);
      return ((v & (v - 3'd1)) == 3'b000);
   endfunction

   assign req_s = {r3, r2, r1, 1'b0};

`ifdef RR_GRANT_SCHED_STATE_RECOVERY_EN
   logic illegal_s;
   logic err_nx_s;

   // Registered grants must always agree with the decode of the registered state.
   assign illegal_s = ({g3, g2, g1} != decode(state_r)) || !onehot0({g3, g2, g1});
`endif

   // Next-state, last-winner and hold-counter decode.
   always_comb begin
      state_nx_s = state_r;
      last_nx_s  = last_r;
      hold_nx_s  = hold_cnt_r;
      grant_en_s = 1'b1;
      cur_s      = state_r;
      win_s      = 2'd0;
`ifdef RR_GRANT_SCHED_STATE_RECOVERY_EN
      err_nx_s   = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            win_s = pick(last_r, req_s);
            if (win_s != 2'd0) begin
               state_nx_s = state_t'(win_s);
               last_nx_s  = win_s;
               hold_nx_s  = '0;
            end else begin
               state_nx_s = IDLE;
            end
         end
         GNT1, GNT2, GNT3: begin
            cur_s = state_r;
            win_s = pick(cur_s, req_s);
            if (!req_s[cur_s]) begin
               // Release takes precedence over timeout; late arrivals are eligible.
               if (win_s != 2'd0) begin
                  state_nx_s = state_t'(win_s);
                  last_nx_s  = win_s;
                  hold_nx_s  = '0;
               end else begin
                  state_nx_s = IDLE;
               end
            end else if (hold_cnt_r < HOLD_LAST) begin
               hold_nx_s = hold_cnt_r + CNT_W'(1);
            end else if (win_s != cur_s) begin
               state_nx_s = state_t'(win_s);
               last_nx_s  = win_s;
               hold_nx_s  = '0;
            end else begin
               hold_nx_s = '0;
            end
         end
         default: begin
            state_nx_s = state_r;
            grant_en_s = 1'b0;
         end
      endcase
`ifdef RR_GRANT_SCHED_STATE_RECOVERY_EN
      if (illegal_s) begin
         state_nx_s = IDLE;
         last_nx_s  = last_r;
         hold_nx_s  = '0;
         grant_en_s = 1'b1;
         err_nx_s   = 1'b1;
      end else begin
         err_nx_s   = 1'b0;
      end
`endif
   end

   assign grant_nx_s = grant_en_s ? decode(state_nx_s) : 3'b000;

   // State, arbitration history and registered grant outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         last_r     <= 2'd3;
         hold_cnt_r <= '0;
         g1         <= 1'b0;
         g2         <= 1'b0;
         g3         <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         last_r     <= last_nx_s;
         hold_cnt_r <= hold_nx_s;
         g1         <= grant_nx_s[0];
         g2         <= grant_nx_s[1];
         g3         <= grant_nx_s[2];
         busy       <= |grant_nx_s;
      end
   end

`ifdef RR_GRANT_SCHED_STATE_RECOVERY_EN
   // One-cycle error pulse following an illegal-state recovery.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else begin
         err <= err_nx_s;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule
